// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths,
// fetch FSM state encoding and common constants.
package if_stage_pkg;

  localparam int ADDR_W  = 32;
  localparam int INST_W  = 32;
  localparam int STALL_W = 6;

  localparam logic [ADDR_W-1:0] ZERO_WORD = '0;
  localparam logic [ADDR_W-1:0] PC_STEP   = 32'd4;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // FETCH: request pending or about to be issued
  // VALID: instruction presented to IF/ID
  // DISCARD: redirected while a request was in flight; its data is dropped
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    VALID   = 2'd1,
    DISCARD = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Fetch bus between the IF stage (master) and the memory controller (slave).
// mem_req is held until a one-cycle mem_done pulse; mem_addr is stable meanwhile.
interface if_stage_if;
  import if_stage_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_done;
  logic [INST_W-1:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_done, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_done, output mem_data);

endinterface

// File: rtl/if_stage_icache.sv
// Direct-mapped instruction cache, one instruction per line.
// Combinational lookup, synchronous write; valid bits clear on rst.
// Only instantiated by if_stage when IF_ICACHE_EN is defined.
module if_icache #(
  parameter int IDX_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [31-IDX_W-2:0] wr_tag,
  input  logic [31:0]        wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic [31-IDX_W-2:0] rd_tag,
  output logic               rd_hit,
  output logic [31:0]        rd_data
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
  logic [LINES-1:0] valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      // per-line valid bit: cleared by reset, set by a fill of this line
      always_ff @(posedge clk) begin
        if (rst)
          valid_q[gi] <= 1'b0;
        else if (wr_en && (wr_idx == IDX_W'(gi)))
          valid_q[gi] <= 1'b1;
      end
    end
  endgenerate

  // tag and data fill on every accepted memory response
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_hit  = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, fetches through the memory
// controller and presents {if_pc, if_inst} to IF/ID.
// Optional feature macro: IF_ICACHE_EN (direct-mapped icache in front of memory).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
`ifdef IF_ICACHE_EN
  , parameter int ICACHE_IDX_W = 7
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [STALL_W-1:0] stall_ctrler,
  input  logic               jump_enable,
  input  logic [ADDR_W-1:0]  jump_addr,
  if_stage_if.master         mem,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INST_W-1:0]  if_inst,
  output logic               if_stall_req
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic              enter_fetch;

  // only bit0 (IF/ID back-pressure) concerns this stage
  logic unused_stall;
  assign unused_stall = ^stall_ctrler[STALL_W-1:1];

`ifdef IF_ICACHE_EN
  logic              cache_hit;
  logic [INST_W-1:0] cache_data;
  logic              cache_wr;

  // fill only from responses accepted in FETCH; DISCARD data is never cached
  assign cache_wr = rdy && (state_q == FETCH) && mem_req_q && mem.mem_done && !jump_enable;

  if_icache #(.IDX_W(ICACHE_IDX_W)) u_icache (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cache_wr),
    .wr_idx  (pc_q[ICACHE_IDX_W+1:2]),
    .wr_tag  (pc_q[31:ICACHE_IDX_W+2]),
    .wr_data (mem.mem_data),
    .rd_idx  (pc_d[ICACHE_IDX_W+1:2]),
    .rd_tag  (pc_d[31:ICACHE_IDX_W+2]),
    .rd_hit  (cache_hit),
    .rd_data (cache_data)
  );
`endif

  // next PC and whether the stage (re)enters FETCH; jump wins over everything
  always_comb begin
    pc_d        = pc_q;
    enter_fetch = 1'b0;
    case (state_q)
      FETCH: begin
        if (jump_enable) begin
          pc_d        = jump_addr;
          enter_fetch = !mem_req_q;
        end
      end
      VALID: begin
        if (jump_enable) begin
          pc_d        = jump_addr;
          enter_fetch = 1'b1;
        end else if (!stall_ctrler[0]) begin
          pc_d        = pc_q + PC_STEP;
          enter_fetch = 1'b1;
        end
      end
      DISCARD: begin
        if (jump_enable)
          pc_d = jump_addr;
        // the in-flight response also retires here even if a new jump lands,
        // otherwise the FSM would wait on a request that already completed
        if (mem.mem_done)
          enter_fetch = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM next-state and bus/output register updates
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    case (state_q)
      FETCH: begin
        if (jump_enable) begin
          // an outstanding request is never aborted: drain it in DISCARD
          if (mem_req_q)
            state_d = DISCARD;
        end else if (mem_req_q) begin
          if (mem.mem_done) begin
            if_inst_d = mem.mem_data;
            if_pc_d   = pc_q;
            mem_req_d = DISABLE;
            state_d   = VALID;
          end
        end else begin
          mem_req_d  = ENABLE;
          mem_addr_d = pc_q;
        end
      end
      VALID: ;
      DISCARD: begin
        if (mem.mem_done)
          mem_req_d = DISABLE;
      end
      default: state_d = FETCH;
    endcase
    if (enter_fetch) begin
      state_d = FETCH;
`ifdef IF_ICACHE_EN
      if (cache_hit) begin
        state_d   = VALID;
        if_pc_d   = pc_d;
        if_inst_d = cache_data;
      end
`endif
    end
  end

  // state registers; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      mem_req_q  <= DISABLE;
      mem_addr_q <= ZERO_WORD;
      if_pc_q    <= ZERO_WORD;
      if_inst_q  <= ZERO_WORD;
    end else if (rdy) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_addr  = mem_addr_q;
  assign if_pc         = if_pc_q;
  assign if_inst       = if_inst_q;
  assign if_stall_req  = (state_q != VALID);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage (default build): sequential fetch, stall hold,
// redirects during an outstanding request and on the mem_done cycle,
// PC wrap, rdy freeze and reset mid-transaction.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [5:0]  stall_ctrler;
  logic        jump_enable;
  logic [31:0] jump_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_stall_req;

  if_stage_if mem_bus ();

  if_stage #(.RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .stall_ctrler (stall_ctrler),
    .jump_enable  (jump_enable),
    .jump_addr    (jump_addr),
    .mem          (mem_bus),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_stall_req (if_stall_req)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] last_req_addr = 32'hDEAD_BEEF;
  logic        req_prev = 1'b0;
  int          mem_cnt  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // memory controller model: mem_done pulses on the 3rd cycle of a held request
  always @(posedge clk) begin
    #2;
    if (rst) begin
      mem_cnt          = 0;
      req_prev         = 1'b0;
      mem_bus.mem_done = 1'b0;
      mem_bus.mem_data = 32'h0;
    end else begin
      mem_bus.mem_done = 1'b0;
      if (mem_bus.mem_req && !req_prev)
        last_req_addr = mem_bus.mem_addr;
      req_prev = mem_bus.mem_req;
      if (mem_bus.mem_req) begin
        mem_cnt++;
        if (mem_cnt == 3) begin
          mem_bus.mem_done = 1'b1;
          mem_bus.mem_data = mem_word(mem_bus.mem_addr);
          mem_cnt          = 0;
        end
      end
    end
  end

  task automatic wait_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (if_stall_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_ready"}, {31'b0, !if_stall_req}, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    @(negedge clk);
    while (!mem_bus.mem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_req"}, {31'b0, mem_bus.mem_req}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!mem_bus.mem_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done"}, {31'b0, mem_bus.mem_done}, 32'd1);
  endtask

  task automatic check_presented(input string tag, input logic [31:0] pc);
    check_eq({tag, "_pc"},   if_pc,   pc);
    check_eq({tag, "_inst"}, if_inst, mem_word(pc));
  endtask

  initial begin
    rst          = 1'b1;
    rdy          = 1'b1;
    stall_ctrler = 6'b0;
    jump_enable  = 1'b0;
    jump_addr    = 32'h0;
    repeat (2) @(negedge clk);

    // reset state
    check_eq("rst_mem_req",   {31'b0, mem_bus.mem_req}, 32'd0);
    check_eq("rst_mem_addr",  mem_bus.mem_addr, 32'h0);
    check_eq("rst_if_pc",     if_pc, 32'h0);
    check_eq("rst_if_inst",   if_inst, 32'h0);
    check_eq("rst_stall_req", {31'b0, if_stall_req}, 32'd1);
    rst = 1'b0;

    // sequential fetch 0, 4: each instruction valid for exactly one cycle
    for (int i = 0; i < 2; i++) begin
      wait_valid("seq");
      check_presented("seq", 32'(i * 4));
      check_eq("seq_req_addr", last_req_addr, 32'(i * 4));
      @(negedge clk);
      check_eq("seq_one_cycle", {31'b0, if_stall_req}, 32'd1);
    end

    // instruction at 8 held by stall for 4 cycles
    wait_valid("stall");
    check_presented("stall_first", 32'h8);
    check_eq("stall_req_addr", last_req_addr, 32'h8);
    stall_ctrler = 6'b000001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_presented("stall_hold", 32'h8);
      check_eq("stall_no_req", {31'b0, mem_bus.mem_req}, 32'd0);
      check_eq("stall_valid",  {31'b0, if_stall_req}, 32'd0);
    end
    stall_ctrler = 6'b0;
    wait_valid("release");
    check_presented("release", 32'hC);
    check_eq("release_req_addr", last_req_addr, 32'hC);

    // jump to 0x100 while the request for 0x10 is outstanding
    wait_req("disc");
    check_eq("disc_addr", mem_bus.mem_addr, 32'h10);
    jump_enable = 1'b1;
    jump_addr   = 32'h100;
    @(negedge clk);
    jump_enable = 1'b0;
    check_eq("disc_stall_req", {31'b0, if_stall_req}, 32'd1);
    check_eq("disc_req_held",  {31'b0, mem_bus.mem_req}, 32'd1);
    check_eq("disc_addr_held", mem_bus.mem_addr, 32'h10);
    wait_valid("disc_target");
    check_presented("disc_target", 32'h100);
    check_eq("disc_req_addr", last_req_addr, 32'h100);

    // jump in the same cycle as mem_done for 0x104
    wait_done("jd");
    check_eq("jd_addr", mem_bus.mem_addr, 32'h104);
    jump_enable = 1'b1;
    jump_addr   = 32'h200;
    @(negedge clk);
    jump_enable = 1'b0;
    check_eq("jd_stall_req", {31'b0, if_stall_req}, 32'd1);
    check_eq("jd_req_held",  {31'b0, mem_bus.mem_req}, 32'd1);
    wait_valid("jd_target");
    check_presented("jd_target", 32'h200);
    check_eq("jd_req_addr", last_req_addr, 32'h200);

    // jump from VALID to the top of the address space, then wrap to 0
    jump_enable = 1'b1;
    jump_addr   = 32'hFFFF_FFFC;
    @(negedge clk);
    jump_enable = 1'b0;
    wait_valid("top");
    check_presented("top", 32'hFFFF_FFFC);
    wait_valid("wrap");
    check_presented("wrap", 32'h0);
    check_eq("wrap_req_addr", last_req_addr, 32'h0);

    // rdy low freezes a valid, unstalled instruction
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_presented("frz", 32'h0);
      check_eq("frz_valid",  {31'b0, if_stall_req}, 32'd0);
      check_eq("frz_no_req", {31'b0, mem_bus.mem_req}, 32'd0);
    end
    rdy = 1'b1;
    wait_valid("unfrz");
    check_presented("unfrz", 32'h4);

    // reset while the request for 8 is outstanding
    wait_req("rmid");
    check_eq("rmid_addr", mem_bus.mem_addr, 32'h8);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rmid_mem_req",   {31'b0, mem_bus.mem_req}, 32'd0);
    check_eq("rmid_mem_addr",  mem_bus.mem_addr, 32'h0);
    check_eq("rmid_if_pc",     if_pc, 32'h0);
    check_eq("rmid_if_inst",   if_inst, 32'h0);
    check_eq("rmid_stall_req", {31'b0, if_stall_req}, 32'd1);
    rst = 1'b0;
    wait_valid("rmid_restart");
    check_presented("rmid_restart", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
